// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and types for the ALU result stage
// Contents: default datapath width, flag bit positions inside {Z,N,C,V},
//           and the state encoding of the two-entry skid buffer.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    // Bit positions of each flag inside the 4-bit flag vector {Z,N,C,V}.
    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 3;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - combinational {Z,N,C,V} derivation from adder outputs
// Ports: sum/cout    - adder Sum bus and carry out
//        a_msb/b_msb - operand MSBs as applied to the adder (B already inverted for subtract)
//        flags       - {Z,N,C,V} indexed by the FLAG_* constants
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    input  logic             a_msb,
    input  logic             b_msb,
    output logic [3:0]       flags
);

    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (sum == '0);
        flags[FLAG_N] = sum[WIDTH-1];
        flags[FLAG_C] = cout;
        // Signed overflow: both operands share a sign and the result sign differs.
        flags[FLAG_V] = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
    end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - two-entry skid buffer holding {sum, flags} plus saturating overflow counter
// Ports: clk, rst_n                          - clock, synchronous active-low reset
//        in_valid/in_ready, in_sum, in_cout,
//        in_a_msb, in_b_msb                  - upstream adder beat
//        out_valid/out_ready, out_result,
//        out_flags                           - oldest held beat and its {Z,N,C,V}
//        ovf_count                           - saturating count of accepted beats with V=1
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_cout,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic [CNT_W-1:0] ovf_count
);

    skid_state_e      state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] sum0_q, sum0_d, sum1_q, sum1_d;
    logic [3:0]       flags0_q, flags0_d, flags1_q, flags1_d;
    logic [CNT_W-1:0] ovf_q, ovf_d;
    logic [3:0]       new_flags;
    logic             accept;
    logic             deliver;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .sum   (in_sum),
        .cout  (in_cout),
        .a_msb (in_a_msb),
        .b_msb (in_b_msb),
        .flags (new_flags)
    );

    // Entry 0 is always the oldest beat; entry 1 only holds data in SKID_TWO.
    assign in_ready   = in_ready_q;
    assign out_valid  = (state_q != SKID_EMPTY);
    assign out_result = sum0_q;
    assign out_flags  = flags0_q;
    assign ovf_count  = ovf_q;

    assign accept  = in_valid && in_ready_q;
    assign deliver = out_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        sum0_d   = sum0_q;
        flags0_d = flags0_q;
        sum1_d   = sum1_q;
        flags1_d = flags1_q;
        ovf_d    = ovf_q;
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    state_d  = SKID_ONE;
                    sum0_d   = in_sum;
                    flags0_d = new_flags;
                end
            end
            SKID_ONE: begin
                if (accept && !deliver) begin
                    state_d  = SKID_TWO;
                    sum1_d   = in_sum;
                    flags1_d = new_flags;
                end else if (!accept && deliver) begin
                    state_d = SKID_EMPTY;
                end else if (accept && deliver) begin
                    sum0_d   = in_sum;
                    flags0_d = new_flags;
                end
            end
            SKID_TWO: begin
                // in_ready_q is low here, so only the drain path exists.
                if (deliver) begin
                    state_d  = SKID_ONE;
                    sum0_d   = sum1_q;
                    flags0_d = flags1_q;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase

        // Registered ready: derived from next state so no out_ready-to-in_ready path exists.
        in_ready_d = (state_d != SKID_TWO);

        if (accept && new_flags[FLAG_V] && (ovf_q != {CNT_W{1'b1}})) begin
            ovf_d = ovf_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= SKID_EMPTY;
            in_ready_q <= 1'b1;
            sum0_q     <= '0;
            flags0_q   <= '0;
            sum1_q     <= '0;
            flags1_q   <= '0;
            ovf_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            sum0_q     <= sum0_d;
            flags0_q   <= flags0_d;
            sum1_q     <= sum1_d;
            flags1_q   <= flags1_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule
